// File: rtl/uart_tx_if.sv
// Byte handshake between a requester and the UART transmitter.
// The master offers data with valid; the transmitter raises ready while it can take a byte.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, stop, with a one-byte holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned BAUD_TICK = CLK_FREQ / BAUD_RATE
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx_o,
    output logic     busy_o,
    output logic     done_o
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    localparam logic [15:0] TickLast = 16'(BAUD_TICK - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic       accept;
    logic       tick;
    logic       load;
    logic [7:0] load_byte;

    assign bus.ready = ~hold_full_q;
    assign accept    = bus.valid & ~hold_full_q;
    assign tick      = (cnt_q == TickLast);

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        load_byte   = bus.data;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (state_q != StIdle && !tick) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    load    = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Chain the next frame with no idle gap: held byte first, else a fresh offer.
                if (tick) begin
                    if (hold_full_q) begin
                        state_d     = StStart;
                        load        = 1'b1;
                        load_byte   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        state_d = StStart;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept && !load) begin
            hold_d      = bus.data;
            hold_full_d = 1'b1;
        end

        if (load) begin
            shift_d = load_byte;
`ifdef UART_TX_PARITY_EN
            parity_d = ^load_byte;
`endif
        end
    end

    // Line outputs follow the state register by one cycle, so tx lags acceptance by one edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != StIdle) || hold_full_q;
        done_d = (state_q == StStop) && tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed bench for uart_tx against a frame-timeline reference model.
// Expected line levels come from the list of frame start edges and their bytes.
module tb_uart_tx;
    localparam int Bt    = 16;
    localparam int DefBt = 50000000 / 9600;
`ifdef UART_TX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif
    localparam int FrameLen    = NBits * Bt;
    localparam int DefFrameLen = NBits * DefBt;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, busy, done;
    logic d_tx, d_busy, d_done;

    uart_tx_if u_if ();
    uart_tx_if d_if ();

    always #5 clk = ~clk;

    uart_tx #(.BAUD_TICK(Bt)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (u_if),
        .tx_o   (tx),
        .busy_o (busy),
        .done_o (done)
    );

    uart_tx dut_def (
        .clk    (clk),
        .rst    (rst),
        .bus    (d_if),
        .tx_o   (d_tx),
        .busy_o (d_busy),
        .done_o (d_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each frame is (start edge, byte); the line is a pure function of those.
    int         edge_n = 0;
    int         fr_start[$];
    logic [7:0] fr_byte[$];
    int         frame_end = -1;
    logic       held = 1'b0;
    logic [7:0] held_byte = 8'h00;
    logic       last_acc = 1'b0;
    int         d_start = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_clear();
        fr_start.delete();
        fr_byte.delete();
        frame_end = -1;
        held      = 1'b0;
        last_acc  = 1'b0;
        d_start   = -1;
    endtask

    task automatic start_frame(input int e, input logic [7:0] b);
        fr_start.push_back(e);
        fr_byte.push_back(b);
        frame_end = e + FrameLen;
    endtask

    task automatic model_edge();
        logic acc;
        edge_n++;
        if (rst) begin
            model_clear();
            return;
        end
        acc      = u_if.valid && !held;
        last_acc = acc;
        if (frame_end >= 0 && edge_n == frame_end) begin
            if (held) begin
                start_frame(edge_n, held_byte);
                held = 1'b0;
            end else if (acc) begin
                start_frame(edge_n, u_if.data);
            end else begin
                frame_end = -1;
            end
        end else if (acc) begin
            if (frame_end < 0) begin
                start_frame(edge_n, u_if.data);
            end else begin
                held      = 1'b1;
                held_byte = u_if.data;
            end
        end
        if (d_if.valid && d_start < 0) d_start = edge_n;
    endtask

    task automatic check_cycle();
        int   c;
        int   s;
        logic e_tx, e_busy, e_done;
        c      = edge_n;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        for (int i = 0; i < fr_start.size(); i++) begin
            s = fr_start[i];
            if (c >= s + 1 && c <= s + FrameLen) begin
                e_tx   = line_bit(fr_byte[i], (c - s - 1) / Bt);
                e_busy = 1'b1;
                e_done = (c == s + FrameLen);
            end
        end
        check_eq("tx", tx, e_tx);
        check_eq("busy", busy, e_busy);
        check_eq("done", done, e_done);
        check_eq("ready", u_if.ready, !held);

        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (d_start >= 0 && c >= d_start + 1 && c <= d_start + DefFrameLen) begin
            e_tx   = line_bit(8'h41, (c - d_start - 1) / DefBt);
            e_busy = 1'b1;
            e_done = (c == d_start + DefFrameLen);
        end
        check_eq("def_tx", d_tx, e_tx);
        check_eq("def_busy", d_busy, e_busy);
        check_eq("def_done", d_done, e_done);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic send(input logic [7:0] b);
        u_if.valid = 1'b1;
        u_if.data  = b;
        step();
        u_if.valid = 1'b0;
    endtask

    task automatic run_until_idle();
        int n = 0;
        while ((frame_end >= 0 || held) && n < 5000) begin
            step();
            n++;
        end
        repeat (3) step();
    endtask

    initial begin
        int s;
        int n;
        u_if.valid = 1'b0;
        u_if.data  = 8'h00;
        d_if.valid = 1'b0;
        d_if.data  = 8'h00;

        #1 rst = 1'b1;
        #1;
        check_eq("reset_tx", tx, 1'b1);
        check_eq("reset_ready", u_if.ready, 1'b1);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Single byte, then back-to-back pair, then the parity reference bytes.
        send(8'hA5);
        run_until_idle();
        send(8'h55);
        send(8'h0F);
        run_until_idle();
        send(8'h07);
        run_until_idle();
        send(8'h03);
        run_until_idle();

        // Backpressure: 0x33 offered continuously while the holding register is full.
        send(8'h11);
        send(8'h22);
        u_if.valid = 1'b1;
        u_if.data  = 8'h33;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 2000);
        u_if.valid = 1'b0;
        run_until_idle();

        // An offer landing on the last stop cycle chains straight into the next frame.
        send(8'h3C);
        while (edge_n + 1 < frame_end) step();
        send(8'hC3);
        run_until_idle();

        // Reset during data bit 3 of 0xFF with 0xAA held; neither may reappear afterwards.
        send(8'hFF);
        s = edge_n;
        send(8'hAA);
        while (edge_n < s + 1 + 4 * Bt + 5) step();
        rst = 1'b1;
        #1;
        model_clear();
        check_eq("midrst_tx", tx, 1'b1);
        check_eq("midrst_ready", u_if.ready, 1'b1);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        step();
        step();
        rst = 1'b0;
        send(8'h00);
        run_until_idle();

        for (int i = 0; i < 1500; i++) begin
            u_if.valid = ($urandom_range(0, 7) == 0);
            u_if.data  = 8'($urandom);
            step();
        end
        u_if.valid = 1'b0;
        run_until_idle();

        // Default parameters: one 0x41 frame at the full bit period.
        d_if.valid = 1'b1;
        d_if.data  = 8'h41;
        step();
        d_if.valid = 1'b0;
        repeat (DefFrameLen + 3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
